uart_hex_history: RTL and testbench

//  Drains received bytes from the UART RX FIFO interface, keeps the last DEPTH bytes in a

---
 rtl/uart_hex_history_if.sv | 32 +++
 rtl/uart_hex_history.sv | 166 ++++++++++++++++
 tb/tb_uart_hex_history.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_history_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_hex_history_if : UART FIFO-side handshake bundle (RX pop, TX push)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_hex_history_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;

  modport master (
    input  rx_empty,
    input  r_data,
    output rd_uart,
    input  tx_full,
    output w_data,
    output wr_uart
  );

  modport slave (
    output rx_empty,
    output r_data,
    input  rd_uart,
    output tx_full,
    input  w_data,
    input  wr_uart
  );
endinterface
`default_nettype wire

// File: rtl/uart_hex_history.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_hex_history : drains UART RX bytes into a DEPTH-byte history shown  |
// | as hex on a 2*DEPTH digit muxed seven-segment display. UART_ECHO_EN adds |
// | echo of each byte to the TX FIFO.                         Rev 1.0        |
// +--------------------------------------------------------------------------+
module uart_hex_history #(
  parameter int DEPTH       = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  uart_hex_history_if.master      uart,
  output logic [2*DEPTH-1:0]      an_o,
  output logic [7:0]              sseg_o,
  output logic [CNT_W-1:0]        byte_cnt_o,
  output logic                    led0_o
);

  localparam int c_NUM_DIGITS = 2 * DEPTH;
  localparam int c_PRE_W      = $clog2(REFRESH_DIV);
  localparam int c_DIG_W      = $clog2(c_NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ECHO = 2'd2
  } state_t;

  state_t                state_q;
  logic [DEPTH-1:0][7:0] hist_q;
  logic [DEPTH-1:0][7:0] hist_d;
  logic                  rd_uart_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic                  led0_q;
  logic [c_PRE_W-1:0]    pre_q;
  logic [c_PRE_W-1:0]    pre_d;
  logic [c_DIG_W-1:0]    dig_q;
  logic [c_DIG_W-1:0]    dig_d;
  logic [8*DEPTH-1:0]    w_hist_flat;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;

  generate
    if (DEPTH > 1) begin : g_hist_multi
      assign hist_d = {hist_q[DEPTH-2:0], uart.r_data};
    end else begin : g_hist_single
      assign hist_d = uart.r_data;
    end
  endgenerate

`ifdef UART_ECHO_EN
  logic       wr_uart_q;
  logic [7:0] w_data_q;

  assign uart.wr_uart = wr_uart_q;
  assign uart.w_data  = w_data_q;
`else
  assign uart.wr_uart = 1'b0;
  assign uart.w_data  = 8'h00;
`endif

  assign uart.rd_uart = rd_uart_q;
  assign byte_cnt_o   = byte_cnt_q;
  assign led0_o       = led0_q;

  // The pop strobe is high during READ; the head byte is still valid then and
  // is captured on the same edge the FIFO pops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hist_q     <= '0;
      rd_uart_q  <= 1'b0;
      byte_cnt_q <= '0;
      led0_q     <= 1'b0;
`ifdef UART_ECHO_EN
      wr_uart_q  <= 1'b0;
      w_data_q   <= 8'h00;
`endif
    end else begin
      rd_uart_q <= 1'b0;
`ifdef UART_ECHO_EN
      wr_uart_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!uart.rx_empty) begin
            state_q   <= S_READ;
            rd_uart_q <= 1'b1;
          end
        end
        S_READ: begin
          hist_q     <= hist_d;
          byte_cnt_q <= byte_cnt_q + 1'b1;
          led0_q     <= ~led0_q;
`ifdef UART_ECHO_EN
          state_q    <= S_ECHO;
`else
          state_q    <= S_IDLE;
`endif
        end
`ifdef UART_ECHO_EN
        S_ECHO: begin
          if (!uart.tx_full) begin
            wr_uart_q <= 1'b1;
            w_data_q  <= hist_q[0];
            state_q   <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    dig_d = dig_q;
    if (pre_q == c_PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      dig_d = (dig_q == c_DIG_W'(c_NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      dig_q <= '0;
    end else begin
      pre_q <= pre_d;
      dig_q <= dig_d;
    end
  end

  // Digit i is simply nibble i of the flattened history (hist[0] in the low byte).
  assign w_hist_flat = hist_q;
  assign w_nibble    = w_hist_flat[{dig_q, 2'b00} +: 4];

  always_comb begin
    case (w_nibble)
      4'h0:    w_seg = 7'h40;
      4'h1:    w_seg = 7'h79;
      4'h2:    w_seg = 7'h24;
      4'h3:    w_seg = 7'h30;
      4'h4:    w_seg = 7'h19;
      4'h5:    w_seg = 7'h12;
      4'h6:    w_seg = 7'h02;
      4'h7:    w_seg = 7'h78;
      4'h8:    w_seg = 7'h00;
      4'h9:    w_seg = 7'h10;
      4'hA:    w_seg = 7'h08;
      4'hB:    w_seg = 7'h03;
      4'hC:    w_seg = 7'h46;
      4'hD:    w_seg = 7'h21;
      4'hE:    w_seg = 7'h06;
      4'hF:    w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  assign an_o   = ~(c_NUM_DIGITS'(1) << dig_q);
  assign sseg_o = {(dig_q != '0), w_seg};

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_history.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_hex_history : randomized self-checking bench with a queue-based  |
// | FIFO/history reference model.                              Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_uart_hex_history;

  localparam int DEPTH = 3;
  localparam int RD    = 4;
  localparam int CW    = 4;
  localparam int ND    = 2 * DEPTH;
`ifdef UART_ECHO_EN
  localparam int ECHO  = 1;
`else
  localparam int ECHO  = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] an;
  logic [7:0]    sseg;
  logic [CW-1:0] byte_cnt;
  logic          led0;

  uart_hex_history_if u_if ();

  uart_hex_history #(
    .DEPTH       (DEPTH),
    .REFRESH_DIV (RD),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (u_if),
    .an_o       (an),
    .sseg_o     (sseg),
    .byte_cnt_o (byte_cnt),
    .led0_o     (led0)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] mh [DEPTH];
  int         total = 0;
  int         rd_pulses = 0;
  int         cyc = 0;
  bit         pend_pop = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void model_push(input logic [7:0] b);
    for (int k = DEPTH - 1; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = b;
    total++;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int exp_dig(input int c);
    return (c / RD) % ND;
  endfunction

  function automatic logic [ND-1:0] exp_an(input int c);
    logic [ND-1:0] one = 1;
    return ~(one << exp_dig(c));
  endfunction

  function automatic logic [7:0] exp_sseg(input int c);
    int         d = exp_dig(c);
    logic [7:0] b = mh[d/2];
    logic [3:0] n = (d % 2 == 1) ? b[7:4] : b[3:0];
    return {(d != 0), seg7(n)};
  endfunction

  // RX FIFO / TX FIFO model: pops after the edge that ends an rd_uart cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_pop = 1'b0;
    end else begin
      if (pend_pop) begin
        model_push(rxq.pop_front());
        pend_pop = 1'b0;
      end
      if (u_if.rd_uart === 1'b1) begin
        rd_pulses++;
        tests++;
        if (rxq.size() == 0) begin
          fails++;
          $display("FAIL rd_on_empty: rd_uart=1 with rx_empty=1, required rd_uart=0");
        end else begin
          pend_pop = 1'b1;
        end
      end
      if (u_if.wr_uart === 1'b1) txq.push_back(u_if.w_data);
    end
    u_if.rx_empty = (rxq.size() == 0);
    u_if.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_assert();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    rxq.delete();
    txq.delete();
    pend_pop  = 1'b0;
    for (int k = 0; k < DEPTH; k++) mh[k] = 8'h00;
    total     = 0;
    rd_pulses = 0;
  endtask

  task automatic reset_release();
    step();
    step();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(output int cycles);
    cycles = 0;
    while ((rxq.size() != 0 || pend_pop) && cycles < 2000) begin
      step();
      cycles++;
    end
    if (rxq.size() != 0 || pend_pop) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", rxq.size());
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset_assert();
    tests++; if (an !== 6'b111110) begin fails++; $display("FAIL reset_an: got %b, required 111110", an); end
    tests++; if (sseg !== 8'h40) begin fails++; $display("FAIL reset_sseg: got %h, required 40", sseg); end
    tests++; if (byte_cnt !== '0) begin fails++; $display("FAIL reset_byte_cnt: got %0d, required 0", byte_cnt); end
    tests++; if (led0 !== 1'b0) begin fails++; $display("FAIL reset_led0: got %b, required 0", led0); end
    tests++; if (u_if.rd_uart !== 1'b0 || u_if.wr_uart !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: rd=%b wr=%b, required 0 0", u_if.rd_uart, u_if.wr_uart);
    end
    tests++; if (u_if.w_data !== 8'h00) begin fails++; $display("FAIL reset_w_data: got %h, required 00", u_if.w_data); end
    reset_release();
  endtask

  task automatic test_pattern();
    int c;
    reset_assert();
    reset_release();
    rxq.push_back(8'hA5);
    rxq.push_back(8'h3F);
    wait_drain(c);
    tests++; if (rd_pulses != 2) begin fails++; $display("FAIL pattern_rd_pulses: got %0d, required 2", rd_pulses); end
    tests++; if (byte_cnt !== 4'd2) begin fails++; $display("FAIL pattern_byte_cnt: got %0d, required 2", byte_cnt); end
    tests++; if (led0 !== 1'b0) begin fails++; $display("FAIL pattern_led0: got %b, required 0", led0); end
    for (int i = 0; i < ND * RD; i++) begin
      logic [7:0] lit;
      int d;
      step();
      d = exp_dig(cyc);
      case (d)
        0: lit = 8'h0E;
        1: lit = 8'hB0;
        2: lit = 8'h92;
        3: lit = 8'h88;
        default: lit = 8'hC0;
      endcase
      tests++;
      if (an !== exp_an(cyc) || sseg !== lit) begin
        fails++;
        $display("FAIL pattern_digit%0d: an=%b sseg=%h, required an=%b sseg=%h", d, an, sseg, exp_an(cyc), lit);
      end
    end
  endtask

  task automatic test_display_scan();
    int c;
    reset_assert();
    reset_release();
    for (int k = 0; k < DEPTH; k++) rxq.push_back(8'($urandom));
    wait_drain(c);
    for (int i = 0; i < 2 * ND * RD; i++) begin
      step();
      tests++;
      if (an !== exp_an(cyc) || sseg !== exp_sseg(cyc)) begin
        fails++;
        $display("FAIL display_scan: cyc %0d an=%b sseg=%h, required an=%b sseg=%h",
                 cyc, an, sseg, exp_an(cyc), exp_sseg(cyc));
      end
    end
  endtask

  task automatic test_idle();
    int         p0 = rd_pulses;
    logic [CW-1:0] b0 = byte_cnt;
    for (int i = 0; i < 1000; i++) begin
      step();
      tests++;
      if (u_if.rd_uart !== 1'b0 || an !== exp_an(cyc) || sseg !== exp_sseg(cyc)) begin
        fails++;
        $display("FAIL idle: rd=%b an=%b sseg=%h, required rd=0 an=%b sseg=%h",
                 u_if.rd_uart, an, sseg, exp_an(cyc), exp_sseg(cyc));
      end
    end
    tests++; if (rd_pulses != p0) begin fails++; $display("FAIL idle_pulses: got %0d, required %0d", rd_pulses, p0); end
    tests++; if (byte_cnt !== b0) begin fails++; $display("FAIL idle_byte_cnt: got %0d, required %0d", byte_cnt, b0); end
  endtask

  task automatic test_back_to_back();
    int c;
    int n = $urandom_range(8, 20);
    int p0 = rd_pulses;
    u_if.tx_full = 1'b0;
    for (int k = 0; k < n; k++) rxq.push_back(8'($urandom));
    wait_drain(c);
    tests++;
    if (c > (2 + ECHO) * n + 8) begin fails++; $display("FAIL b2b_throughput: %0d cycles for %0d bytes, required <= %0d", c, n, (2 + ECHO) * n + 8); end
    tests++; if (rd_pulses - p0 != n) begin fails++; $display("FAIL b2b_pulses: got %0d, required %0d", rd_pulses - p0, n); end
    tests++; if (byte_cnt !== CW'(total)) begin fails++; $display("FAIL b2b_byte_cnt: got %0d, required %0d", byte_cnt, CW'(total)); end
    tests++; if (led0 !== total[0]) begin fails++; $display("FAIL b2b_led0: got %b, required %b", led0, total[0]); end
    for (int i = 0; i < ND * RD; i++) begin
      step();
      tests++;
      if (an !== exp_an(cyc) || sseg !== exp_sseg(cyc)) begin
        fails++;
        $display("FAIL b2b_display: an=%b sseg=%h, required an=%b sseg=%h", an, sseg, exp_an(cyc), exp_sseg(cyc));
      end
    end
  endtask

  task automatic test_gaps();
    int c;
    int n = $urandom_range(5, 12);
    for (int k = 0; k < n; k++) begin
      rxq.push_back(8'($urandom));
      repeat ($urandom_range(0, 6)) step();
      tests++;
      if (an !== exp_an(cyc)) begin fails++; $display("FAIL gaps_an: got %b, required %b", an, exp_an(cyc)); end
    end
    wait_drain(c);
    tests++; if (byte_cnt !== CW'(total)) begin fails++; $display("FAIL gaps_byte_cnt: got %0d, required %0d", byte_cnt, CW'(total)); end
    tests++; if (led0 !== total[0]) begin fails++; $display("FAIL gaps_led0: got %b, required %b", led0, total[0]); end
    for (int i = 0; i < ND * RD; i++) begin
      step();
      tests++;
      if (sseg !== exp_sseg(cyc)) begin
        fails++;
        $display("FAIL gaps_display: sseg=%h, required %h", sseg, exp_sseg(cyc));
      end
    end
  endtask

  task automatic test_wrap();
    int c;
    reset_assert();
    reset_release();
    for (int k = 0; k < 17; k++) rxq.push_back(8'($urandom));
    wait_drain(c);
    tests++; if (byte_cnt !== 4'd1) begin fails++; $display("FAIL wrap_byte_cnt: got %0d, required 1", byte_cnt); end
    tests++; if (led0 !== 1'b1) begin fails++; $display("FAIL wrap_led0: got %b, required 1", led0); end
  endtask

  task automatic test_echo();
    int c;
    reset_assert();
    reset_release();
`ifdef UART_ECHO_EN
    u_if.tx_full = 1'b1;
    rxq.push_back(8'h55);
    rxq.push_back(8'h66);
    repeat (30) step();
    tests++; if (rd_pulses != 1) begin fails++; $display("FAIL echo_backpressure_pulses: got %0d, required 1", rd_pulses); end
    tests++; if (txq.size() != 0) begin fails++; $display("FAIL echo_backpressure_push: got %0d pushes, required 0", txq.size()); end
    u_if.tx_full = 1'b0;
    wait_drain(c);
    tests++;
    if (txq.size() != 2 || txq[0] !== 8'h55 || txq[1] !== 8'h66) begin
      fails++;
      $display("FAIL echo_data: got %0d pushes first=%h last=%h, required 2 pushes 55 66",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx);
    end
    tests++; if (rd_pulses != 2) begin fails++; $display("FAIL echo_pulses: got %0d, required 2", rd_pulses); end
    repeat (5) step();
    tests++; if (u_if.w_data !== 8'h66 || u_if.wr_uart !== 1'b0) begin
      fails++; $display("FAIL echo_hold: w_data=%h wr=%b, required 66 0", u_if.w_data, u_if.wr_uart);
    end
`else
    for (int k = 0; k < 6; k++) rxq.push_back(8'($urandom));
    for (int i = 0; i < 30; i++) begin
      u_if.tx_full = 1'($urandom);
      step();
      tests++;
      if (u_if.wr_uart !== 1'b0 || u_if.w_data !== 8'h00) begin
        fails++; $display("FAIL noecho_tx: wr=%b w_data=%h, required 0 00", u_if.wr_uart, u_if.w_data);
      end
    end
    u_if.tx_full = 1'b0;
    wait_drain(c);
    tests++; if (rd_pulses != 6) begin fails++; $display("FAIL noecho_pulses: got %0d, required 6", rd_pulses); end
`endif
  endtask

  task automatic test_reset_midrun();
    reset_assert();
    reset_release();
    u_if.tx_full = 1'b1;
    for (int k = 0; k < 3; k++) rxq.push_back(8'($urandom));
    repeat (6) step();
    test_reset();
    u_if.tx_full = 1'b0;
    step();
    tests++; if (an !== 6'b111110 || sseg !== 8'h40) begin
      fails++; $display("FAIL midrun_restart: an=%b sseg=%h, required 111110 40", an, sseg);
    end
    repeat (20) step();
    tests++; if (txq.size() != 0) begin fails++; $display("FAIL midrun_echo_discard: got %0d pushes, required 0", txq.size()); end
    tests++; if (byte_cnt !== '0 || rd_pulses != 0) begin
      fails++; $display("FAIL midrun_quiet: byte_cnt=%0d pulses=%0d, required 0 0", byte_cnt, rd_pulses);
    end
  endtask

  initial begin
    u_if.tx_full  = 1'b0;
    u_if.rx_empty = 1'b1;
    u_if.r_data   = 8'h00;
    for (int k = 0; k < DEPTH; k++) mh[k] = 8'h00;
    test_reset();
    test_pattern();
    test_display_scan();
    test_idle();
    test_back_to_back();
    test_gaps();
    test_wrap();
    test_echo();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
